// File: rtl/keeper_zone_control.sv
// keeper_zone_control: one penalty round per start pulse.
// Arms a target zone (forced or LFSR-picked), highlights it for a countdown,
// judges the cursor against it, shows the result colour and reports the
// outcome with saturating goal/save tallies. The block also sits inline in the
// VGA pixel chain and adds exactly one cycle of latency to timing and colour.
module keeper_zone_control #(
    parameter int          CLK_HZ       = 65_000_000,
    parameter int          COUNTDOWN_MS = 1000,
    parameter int          RESULT_MS    = 1000,
    parameter int          ZONES        = 4,
    parameter int          ZONE_X0      = 200,
    parameter int          ZONE_Y0      = 200,
    parameter int          ZONE_W       = 100,
    parameter int          ZONE_H       = 100,
    parameter int          ZONE_PITCH   = 150,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        round_start,
    input  logic        abort,
    input  logic        force_en,
    input  logic [2:0]  force_zone,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] in_hcount,
    input  logic [10:0] in_vcount,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_hblnk,
    input  logic        in_vblnk,
    input  logic [11:0] in_rgb,
    output logic [10:0] out_hcount,
    output logic [10:0] out_vcount,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_hblnk,
    output logic        out_vblnk,
    output logic [11:0] out_rgb,
    output logic [2:0]  target_zone,
    output logic        busy,
    output logic        is_scored,
    output logic        round_done,
    output logic [7:0]  goals,
    output logic [7:0]  saves
);

    // Round states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARM       = 3'd1;
    localparam logic [2:0] S_COUNTDOWN = 3'd2;
    localparam logic [2:0] S_JUDGE     = 3'd3;
    localparam logic [2:0] S_GOAL      = 3'd4;
    localparam logic [2:0] S_SAVE      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    // Phase lengths in clock ticks; a zero-length phase is stretched to one
    // tick so the terminal-count compare stays meaningful.
    localparam int T_CD      = CLK_HZ / 1000 * COUNTDOWN_MS;
    localparam int T_RES     = CLK_HZ / 1000 * RESULT_MS;
    localparam int T_CD_EFF  = (T_CD  < 1) ? 1 : T_CD;
    localparam int T_RES_EFF = (T_RES < 1) ? 1 : T_RES;
    localparam int T_MAX     = (T_CD_EFF > T_RES_EFF) ? T_CD_EFF : T_RES_EFF;
    localparam int CNT_W     = (T_MAX < 2) ? 1 : $clog2(T_MAX);

    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(T_CD_EFF - 1);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(T_RES_EFF - 1);

    localparam logic [11:0] RGB_TARGET = 12'h00F;
    localparam logic [11:0] RGB_GOAL   = 12'hF00;
    localparam logic [11:0] RGB_SAVE   = 12'h0F0;

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       target_q, target_d;
    logic             goalFlag_q, goalFlag_d;
    logic [7:0]       goals_q,  goals_d;
    logic [7:0]       saves_q,  saves_d;
    logic [15:0]      lfsr_q,   lfsr_d;

    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q, rgb_d;

    logic [2:0] targetSel;
    logic       cursorInTarget;
    logic       pixelInTarget;

    // Half-open rectangle test for zone z; both ranges exclude the far edge.
    function automatic logic inZone(input logic [11:0] x, input logic [11:0] y,
                                    input logic [2:0] z);
        int left;
        left = ZONE_X0 + int'(z) * ZONE_PITCH;
        return (int'(x) >= left) && (int'(x) < left + ZONE_W) &&
               (int'(y) >= ZONE_Y0) && (int'(y) < ZONE_Y0 + ZONE_H);
    endfunction

    // Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Free-running target generator, restarted from the seed on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Zone candidate for the next round and the geometric hit tests.
    always_comb begin
        targetSel      = force_en ? 3'(32'(force_zone) % ZONES)
                                  : 3'(32'(lfsr_q) % ZONES);
        cursorInTarget = inZone(xpos, ypos, target_q);
        pixelInTarget  = inZone({1'b0, in_hcount}, {1'b0, in_vcount}, target_q);
    end

    // Round sequencing, phase timing and tally updates; abort overrides all.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        goalFlag_d = goalFlag_q;
        goals_d    = goals_q;
        saves_d    = saves_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (round_start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                target_d = targetSel;
                cnt_d    = '0;
                state_d  = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (cnt_q == CD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_JUDGE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_JUDGE: begin
                cnt_d      = '0;
                goalFlag_d = !cursorInTarget;
                state_d    = cursorInTarget ? S_SAVE : S_GOAL;
            end
            S_GOAL, S_SAVE: begin
                if (cnt_q == RES_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (state_q == S_GOAL) begin
                        if (goals_q != 8'hFF) begin
                            goals_d = goals_q + 8'd1;
                        end
                    end else begin
                        if (saves_q != 8'hFF) begin
                            saves_d = saves_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            goalFlag_d = 1'b0;
            goals_d    = goals_q;
            saves_d    = saves_q;
        end
    end

    // Round state registers; a mid-round reset also clears the tallies.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            target_q   <= 3'd0;
            goalFlag_q <= 1'b0;
            goals_q    <= 8'd0;
            saves_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            goalFlag_q <= goalFlag_d;
            goals_q    <= goals_d;
            saves_q    <= saves_d;
        end
    end

    // Colour the target zone according to the current phase.
    always_comb begin
        rgb_d = in_rgb;
        if (pixelInTarget) begin
            case (state_q)
                S_COUNTDOWN: rgb_d = RGB_TARGET;
                S_GOAL:      rgb_d = RGB_GOAL;
                S_SAVE:      rgb_d = RGB_SAVE;
                default:     rgb_d = in_rgb;
            endcase
        end
    end

    // Single pipeline stage keeping timing and colour aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= 12'd0;
        end else begin
            hcount_q <= in_hcount;
            vcount_q <= in_vcount;
            hsync_q  <= in_hsync;
            vsync_q  <= in_vsync;
            hblnk_q  <= in_hblnk;
            vblnk_q  <= in_vblnk;
            rgb_q    <= rgb_d;
        end
    end

    assign out_hcount  = hcount_q;
    assign out_vcount  = vcount_q;
    assign out_hsync   = hsync_q;
    assign out_vsync   = vsync_q;
    assign out_hblnk   = hblnk_q;
    assign out_vblnk   = vblnk_q;
    assign out_rgb     = rgb_q;

    assign target_zone = target_q;
    assign busy        = (state_q != S_IDLE);
    assign is_scored   = (state_q == S_GOAL) || ((state_q == S_DONE) && goalFlag_q);
    assign round_done  = (state_q == S_DONE);
    assign goals       = goals_q;
    assign saves       = saves_q;

endmodule

// File: tb/tb_keeper_zone_control.sv
// Directed bench for keeper_zone_control with short ms timing:
// one tick per ms, 5-tick countdown, 3-tick result display.
module tb_keeper_zone_control;

    localparam int ZONES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        round_start, abort, force_en;
    logic [2:0]  force_zone;
    logic [11:0] xpos, ypos;
    logic [10:0] in_hcount, in_vcount;
    logic        in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [11:0] in_rgb;
    logic [10:0] out_hcount, out_vcount;
    logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
    logic [11:0] out_rgb;
    logic [2:0]  target_zone;
    logic        busy, is_scored, round_done;
    logic [7:0]  goals, saves;

    int checks   = 0;
    int failures = 0;

    logic [15:0] modelLfsr;

    keeper_zone_control #(
        .CLK_HZ(1000), .COUNTDOWN_MS(5), .RESULT_MS(3), .ZONES(ZONES),
        .ZONE_X0(200), .ZONE_Y0(200), .ZONE_W(100), .ZONE_H(100),
        .ZONE_PITCH(150), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .round_start(round_start), .abort(abort),
        .force_en(force_en), .force_zone(force_zone), .xpos(xpos), .ypos(ypos),
        .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb), .out_hcount(out_hcount), .out_vcount(out_vcount),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblnk(out_hblnk),
        .out_vblnk(out_vblnk), .out_rgb(out_rgb), .target_zone(target_zone),
        .busy(busy), .is_scored(is_scored), .round_done(round_done),
        .goals(goals), .saves(saves)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11 (1-based), seeded on reset.
    always @(posedge clk) begin
        if (!rst) modelLfsr <= 16'hACE1;
        else      modelLfsr <= {modelLfsr[14:0],
                                modelLfsr[15] ^ modelLfsr[13] ^ modelLfsr[12] ^ modelLfsr[10]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Plays one full round from IDLE back to IDLE (12 observation steps).
    // With verbose set the pixel must sit inside the expected zone.
    task automatic playRound(input bit verbose, input bit expGoal,
                             input int expGoals, input int expSaves);
        logic [2:0]  expZone;
        logic [11:0] expRgb;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        if (verbose) checkOutput("busy_arm", 32'(busy), 32'd1);
        expZone = force_en ? 3'(32'(force_zone) % ZONES) : 3'(32'(modelLfsr) % ZONES);
        for (int k = 2; k <= 12; k++) begin
            step();
            if (k == 2) checkOutput("target_zone", 32'(target_zone), 32'(expZone));
            if (verbose) begin
                if (k >= 3 && k <= 7)       expRgb = 12'h00F;
                else if (k >= 9 && k <= 11) expRgb = expGoal ? 12'hF00 : 12'h0F0;
                else                        expRgb = 12'h555;
                checkOutput("round_rgb", 32'(out_rgb), 32'(expRgb));
                checkOutput("round_done_pulse", 32'(round_done), (k == 11) ? 32'd1 : 32'd0);
                checkOutput("busy_round", 32'(busy), (k == 12) ? 32'd0 : 32'd1);
                if (k >= 8 && k <= 11)
                    checkOutput("is_scored", 32'(is_scored), 32'(expGoal));
                if (k == 12)
                    checkOutput("is_scored_idle", 32'(is_scored), 32'd0);
                if (k == 11) begin
                    checkOutput("goals_done", 32'(goals), 32'(expGoals));
                    checkOutput("saves_done", 32'(saves), 32'(expSaves));
                end
            end
        end
    endtask

    // Boundary points around zone 2 (x 500..599, y 200..299).
    int sweepX [10] = '{499, 500, 599, 600, 550, 550, 550, 550,   0, 550};
    int sweepY [10] = '{250, 250, 250, 250, 199, 200, 299, 300,   0, 250};
    logic [11:0] sweepRgb [10] = '{12'h555, 12'h00F, 12'h00F, 12'h555, 12'h555,
                                   12'h00F, 12'h00F, 12'h555, 12'h555, 12'h00F};

    task automatic applyStimulus();
        // Reset state
        rst = 1'b0; round_start = 1'b0; abort = 1'b0; force_en = 1'b1;
        force_zone = 3'd2; xpos = 12'd500; ypos = 12'd250;
        in_hcount = 11'd550; in_vcount = 11'd250; in_rgb = 12'h555;
        in_hsync = 1'b0; in_vsync = 1'b0; in_hblnk = 1'b0; in_vblnk = 1'b0;
        step(); step();
        checkOutput("rst_busy",   32'(busy),        32'd0);
        checkOutput("rst_done",   32'(round_done),  32'd0);
        checkOutput("rst_scored", 32'(is_scored),   32'd0);
        checkOutput("rst_goals",  32'(goals),       32'd0);
        checkOutput("rst_saves",  32'(saves),       32'd0);
        checkOutput("rst_target", 32'(target_zone), 32'd0);
        checkOutput("rst_rgb",    32'(out_rgb),     32'd0);
        rst = 1'b1;
        step();
        checkOutput("idle_pass_rgb", 32'(out_rgb), 32'h555);

        // Cursor on the left edge of zone 2: save
        playRound(1'b1, 1'b0, 0, 1);

        // Cursor just past the right edge: goal
        xpos = 12'd600;
        playRound(1'b1, 1'b1, 1, 1);

        // Two rounds sweeping pixels across zone 2 while it is highlighted
        xpos = 12'd0; ypos = 12'd0;
        for (int r = 0; r < 2; r++) begin
            round_start = 1'b1;
            step();
            round_start = 1'b0;
            step();
            for (int j = 0; j < 5; j++) begin
                in_hcount = 11'(sweepX[r*5+j]);
                in_vcount = 11'(sweepY[r*5+j]);
                in_hsync  = j[0];
                step();
                checkOutput("sweep_rgb",    32'(out_rgb),    32'(sweepRgb[r*5+j]));
                checkOutput("sweep_hsync",  32'(out_hsync),  32'(j[0]));
                checkOutput("sweep_hcount", 32'(out_hcount), 32'(sweepX[r*5+j]));
            end
            for (int k = 0; k < 5; k++) step();
        end
        checkOutput("sweep_goals", 32'(goals), 32'd3);
        in_hcount = 11'd550; in_vcount = 11'd250; in_hsync = 1'b0;

        // Abort on the last countdown cycle
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_idle", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("abort_no_done", 32'(round_done), 32'd0);
            step();
        end
        checkOutput("abort_goals", 32'(goals), 32'd3);
        checkOutput("abort_saves", 32'(saves), 32'd1);

        // Start and abort together in IDLE: start wins, then abort in ARM
        round_start = 1'b1; abort = 1'b1;
        step();
        round_start = 1'b0;
        checkOutput("start_beats_abort", 32'(busy), 32'd1);
        step();
        abort = 1'b0;
        checkOutput("abort_in_arm", 32'(busy), 32'd0);
        step();

        // Back-to-back LFSR-driven rounds, cursor never in a zone
        force_en = 1'b0;
        for (int n = 0; n < 300; n++) playRound(1'b0, 1'b1, 0, 0);
        checkOutput("goals_saturate", 32'(goals), 32'd255);
        checkOutput("saves_kept",     32'(saves), 32'd1);

        // Reset in GOAL, with ignored start pulses during the countdown
        force_en = 1'b1; xpos = 12'd600; ypos = 12'd250;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            round_start = (k == 3 || k == 5);
            step();
        end
        round_start = 1'b0;
        checkOutput("goal_scored_mid", 32'(is_scored), 32'd1);
        checkOutput("goal_busy_mid",   32'(busy),      32'd1);
        rst = 1'b0;
        step();
        checkOutput("mid_rst_busy",   32'(busy),        32'd0);
        checkOutput("mid_rst_scored", 32'(is_scored),   32'd0);
        checkOutput("mid_rst_done",   32'(round_done),  32'd0);
        checkOutput("mid_rst_goals",  32'(goals),       32'd0);
        checkOutput("mid_rst_saves",  32'(saves),       32'd0);
        checkOutput("mid_rst_target", 32'(target_zone), 32'd0);
        checkOutput("mid_rst_rgb",    32'(out_rgb),     32'd0);
        rst = 1'b1;
        step();
        checkOutput("post_rst_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
